// File: rtl/mipi_wr_pkg.sv
// Shared types and helpers for the MIPI frame write path.
//   wr_state_e   : write scheduler states
//   NUM_BANKS    : depth of the frame buffer ring
//   next_wr_bank : triple-buffer bank rotation, skipping the bank being read
package mipi_wr_pkg;

  localparam int unsigned NUM_BANKS = 3;
  localparam int unsigned BANK_W    = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LINE,
    S_LINE,
    S_REQ,
    S_FRAME_END
  } wr_state_e;

  // Next bank after last_bank; if that one is being read, skip one more.
  function automatic logic [BANK_W-1:0] next_wr_bank(input logic [BANK_W-1:0] last_bank,
                                                     input logic [BANK_W-1:0] rd_bank);
    logic [BANK_W-1:0] nb;
    nb = BANK_W'((32'(last_bank) + 32'd1) % NUM_BANKS);
    if (nb == rd_bank) nb = BANK_W'((32'(last_bank) + 32'd2) % NUM_BANKS);
    return nb;
  endfunction

endpackage

// File: rtl/mipi_wr_bank_sel.sv
// Combinational triple-buffer bank selector (shared with the read side).
//   last_bank   : last fully written bank
//   rd_bank     : bank currently owned by the reader
//   next_bank_c : bank to write next
module mipi_wr_bank_sel
  import mipi_wr_pkg::*;
(
  input  logic [BANK_W-1:0] last_bank,
  input  logic [BANK_W-1:0] rd_bank,
  output logic [BANK_W-1:0] next_bank_c
);

  assign next_bank_c = next_wr_bank(last_bank, rd_bank);

endmodule

// File: rtl/mipi_frame_wr_ctrl.sv
// Write-side scheduler between the MIPI unpacker and the DDR3 write port.
// Measures each line of the unpacked stream, issues one burst request per
// line, rotates the triple frame buffer and flags short frames / overruns.
// Optional build macro FRAME_STATS_EN adds O_Err_Cnt and O_Frame_Cnt.
//   I_CLK, I_Rst_n          : clock, async active-low reset
//   I_Mipi_Unpacket_Vaild   : line valid (high for one line)
//   I_Mipi_Unpacket_V_sync  : frame sync, rising edge = frame start
//   I_Rd_Bank               : bank held by the HDMI reader
//   I_Wr_Ack                : DDR3 port accepted the request
//   O_Wr_Req/Addr/Len       : burst write request, byte address, beat count
//   O_Wr_Bank               : last completed bank
//   O_Frame_Done/Err        : one-cycle frame complete / error pulses
//   O_Line_Cnt              : lines acknowledged in the current frame
module mipi_frame_wr_ctrl
  import mipi_wr_pkg::*;
#(
  parameter int unsigned Image_H     = 1080,
  parameter int unsigned Image_W     = 1920,
  parameter int unsigned ADDR_W      = 28,
  parameter int unsigned LINE_STRIDE = 4096,
  parameter logic [31:0] FRAME_SIZE  = 32'h0080_0000
) (
  input  logic              I_CLK,
  input  logic              I_Rst_n,
  input  logic              I_Mipi_Unpacket_Vaild,
  input  logic              I_Mipi_Unpacket_V_sync,
  input  logic [1:0]        I_Rd_Bank,
  input  logic              I_Wr_Ack,
  output logic              O_Wr_Req,
  output logic [ADDR_W-1:0] O_Wr_Addr,
  output logic [15:0]       O_Wr_Len,
  output logic [1:0]        O_Wr_Bank,
  output logic              O_Frame_Done,
  output logic              O_Frame_Err,
  output logic [15:0]       O_Line_Cnt
`ifdef FRAME_STATS_EN
  ,
  output logic [9:0]        O_Err_Cnt,
  output logic [15:0]       O_Frame_Cnt
`endif
);

  // Line length must fit the 16-bit beat counter.
  if (Image_W == 0 || Image_W > 65535) begin : g_bad_image_w
    $error("Image_W must be in 1..65535");
  end

  wr_state_e         state_q, state_d;
  logic              vs_q, vld_q;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [15:0]       word_q, word_d;
  logic [15:0]       line_d;
  logic              req_d, done_d, err_d;
  logic [ADDR_W-1:0] addr_d;
  logic [15:0]       len_d;
  logic [1:0]        wr_bank_d;
  logic [BANK_W-1:0] nb_c;
  logic              vs_rise, vld_rise;

  // Edges against the previous-cycle copy of each strobe.
  assign vs_rise  = I_Mipi_Unpacket_V_sync & ~vs_q;
  assign vld_rise = I_Mipi_Unpacket_Vaild  & ~vld_q;

  mipi_wr_bank_sel u_bank_sel (
    .last_bank   (O_Wr_Bank),
    .rd_bank     (I_Rd_Bank),
    .next_bank_c (nb_c)
  );

  // State and output registers.
  always_ff @(posedge I_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      state_q      <= S_IDLE;
      vs_q         <= 1'b0;
      vld_q        <= 1'b0;
      bank_q       <= '0;
      word_q       <= '0;
      O_Line_Cnt   <= '0;
      O_Wr_Req     <= 1'b0;
      O_Wr_Addr    <= '0;
      O_Wr_Len     <= '0;
      O_Wr_Bank    <= '0;
      O_Frame_Done <= 1'b0;
      O_Frame_Err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_q         <= I_Mipi_Unpacket_V_sync;
      vld_q        <= I_Mipi_Unpacket_Vaild;
      bank_q       <= bank_d;
      word_q       <= word_d;
      O_Line_Cnt   <= line_d;
      O_Wr_Req     <= req_d;
      O_Wr_Addr    <= addr_d;
      O_Wr_Len     <= len_d;
      O_Wr_Bank    <= wr_bank_d;
      O_Frame_Done <= done_d;
      O_Frame_Err  <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    word_d    = word_q;
    line_d    = O_Line_Cnt;
    req_d     = O_Wr_Req;
    addr_d    = O_Wr_Addr;
    len_d     = O_Wr_Len;
    wr_bank_d = O_Wr_Bank;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (vs_rise) begin
          bank_d  = nb_c;
          line_d  = '0;
          state_d = S_WAIT_LINE;
        end
      end

      S_WAIT_LINE: begin
        if (vs_rise) begin
          err_d   = 1'b1;
          bank_d  = nb_c;
          line_d  = '0;
        end else if (vld_rise) begin
          word_d  = 16'd1;
          state_d = S_LINE;
        end
      end

      S_LINE: begin
        if (vs_rise) begin
          err_d   = 1'b1;
          bank_d  = nb_c;
          line_d  = '0;
          state_d = S_WAIT_LINE;
        end else if (I_Mipi_Unpacket_Vaild) begin
          if (word_q != 16'hFFFF) word_d = word_q + 16'd1;
        end else begin
          len_d   = word_q;
          addr_d  = ADDR_W'(64'(bank_q) * 64'(FRAME_SIZE) +
                            64'(O_Line_Cnt) * 64'(LINE_STRIDE));
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        // Frame restart wins over a simultaneous ack.
        if (vs_rise) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          bank_d  = nb_c;
          line_d  = '0;
          state_d = S_WAIT_LINE;
        end else if (vld_rise) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = S_IDLE;
        end else if (I_Wr_Ack) begin
          req_d   = 1'b0;
          line_d  = O_Line_Cnt + 16'd1;
          state_d = (line_d == 16'(Image_H)) ? S_FRAME_END : S_WAIT_LINE;
        end
      end

      S_FRAME_END: begin
        done_d    = 1'b1;
        wr_bank_d = bank_q;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

`ifdef FRAME_STATS_EN
  // Frame and error statistics.
  always_ff @(posedge I_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      O_Err_Cnt   <= '0;
      O_Frame_Cnt <= '0;
    end else begin
      if (O_Frame_Err && O_Err_Cnt != 10'h3FF) O_Err_Cnt <= O_Err_Cnt + 10'd1;
      if (O_Frame_Done) O_Frame_Cnt <= O_Frame_Cnt + 16'd1;
    end
  end
`else
  // Statistics not built.
`endif

endmodule
